// File: rtl/midi_tx.sv
// MIDI serial transmitter: frames a 1-3 byte MIDI message (status, data1, data2)
// onto a 31.25 kbaud-style UART line, message length derived from the status byte.
module midi_tx #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 31250,
    parameter int REG_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_WIDTH-1:0] status,
    input  logic [REG_WIDTH-1:0] data1,
    input  logic [REG_WIDTH-1:0] data2,
    input  logic                 send,
    output logic                 midi_out,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [1:0]    len_q, len_d;
    logic [7:0]    status_q, status_d;
    logic [7:0]    data1_q, data1_d;
    logic [7:0]    data2_q, data2_d;
    logic          midi_out_q, midi_out_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          bitEnd;
    logic [7:0]    curByte;

    // Number of bytes in a message, from its status byte (status[7] already known set).
    function automatic logic [1:0] msgLen(input logic [7:0] s);
        logic [1:0] n;
        case (s[7:4])
            4'h8, 4'h9, 4'hA, 4'hB, 4'hE: n = 2'd3;
            4'hC, 4'hD:                   n = 2'd2;
            4'hF: begin
                case (s[3:0])
                    4'h1, 4'h3: n = 2'd2;
                    4'h2:       n = 2'd3;
                    default:    n = 2'd1;
                endcase
            end
            default: n = 2'd1;
        endcase
        return n;
    endfunction

    assign bitEnd = (timer_q == TIMER_LAST);

    always_comb begin
        case (byte_q)
            2'd0:    curByte = status_q;
            2'd1:    curByte = data1_q;
            default: curByte = data2_q;
        endcase
    end

    // bit_q walks the frame: 0 = start, 1..8 = data bits 0..7, 9 = stop.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q + 1'b1;
        bit_d      = bit_q;
        byte_d     = byte_q;
        len_d      = len_q;
        status_d   = status_q;
        data1_d    = data1_q;
        data2_d    = data2_q;
        midi_out_d = midi_out_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d    = '0;
                midi_out_d = 1'b1;
                busy_d     = 1'b0;
                if (send) begin
                    if (status[7]) begin
                        state_d    = START;
                        status_d   = status[7:0];
                        data1_d    = {1'b0, data1[6:0]};
                        data2_d    = {1'b0, data2[6:0]};
                        len_d      = msgLen(status[7:0]);
                        byte_d     = 2'd0;
                        bit_d      = 4'd0;
                        midi_out_d = 1'b0;
                        busy_d     = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            START: begin
                if (bitEnd) begin
                    timer_d    = '0;
                    state_d    = DATA;
                    bit_d      = 4'd1;
                    midi_out_d = curByte[0];
                end
            end
            DATA: begin
                if (bitEnd) begin
                    timer_d = '0;
                    if (bit_q == 4'd8) begin
                        state_d    = STOP;
                        bit_d      = 4'd9;
                        midi_out_d = 1'b1;
                    end else begin
                        bit_d      = bit_q + 4'd1;
                        midi_out_d = curByte[bit_q[2:0]];
                    end
                end
            end
            STOP: begin
                if (bitEnd) begin
                    timer_d = '0;
                    bit_d   = 4'd0;
                    if ((byte_q + 2'd1) < len_q) begin
                        state_d    = START;
                        byte_d     = byte_q + 2'd1;
                        midi_out_d = 1'b0;
                    end else begin
                        state_d    = IDLE;
                        byte_d     = 2'd0;
                        midi_out_d = 1'b1;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                midi_out_d = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            len_q      <= '0;
            status_q   <= '0;
            data1_q    <= '0;
            data2_q    <= '0;
            midi_out_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            len_q      <= len_d;
            status_q   <= status_d;
            data1_q    <= data1_d;
            data2_q    <= data2_d;
            midi_out_q <= midi_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign midi_out = midi_out_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_midi_tx.sv
// Bench for midi_tx: table of messages with expected length/err, a line monitor
// that decodes UART frames and checks them against a queue of expected bytes.
`timescale 1ns/1ps
module tb_midi_tx;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] status = '0;
    logic [7:0] data1 = '0;
    logic [7:0] data2 = '0;
    logic       send = 1'b0;
    logic       midi_out, busy, done, err;

    int nVectors = 0;
    int nMiscompares = 0;

    logic [7:0] expQ[$];

    typedef struct {
        logic [7:0] st;
        logic [7:0] d1;
        logic [7:0] d2;
        int         len;
        bit         isErr;
    } vec_t;

    vec_t tbl[17];

    midi_tx #(
        .CLK_FREQ (312500),
        .BAUD     (31250),
        .REG_WIDTH(8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .status  (status),
        .data1   (data1),
        .data2   (data2),
        .send    (send),
        .midi_out(midi_out),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line monitor: samples mid-bit on falling edges, pops the expected byte at each stop bit.
    int         monCnt = 0;
    bit         monActive = 0;
    logic [7:0] monShift = '0;

    always @(negedge clk) begin
        if (!rst) begin
            monActive = 0;
            monCnt    = 0;
        end else if (!monActive) begin
            if (midi_out == 1'b0) begin
                monActive = 1;
                monCnt    = 0;
            end
        end else begin
            monCnt++;
            if (monCnt == 5)
                checkOutput("start bit", {31'd0, midi_out}, 32'd0);
            if (monCnt >= 15 && monCnt <= 85 && (monCnt % 10) == 5)
                monShift[(monCnt - 15) / 10] = midi_out;
            if (monCnt == 95) begin
                checkOutput("stop bit", {31'd0, midi_out}, 32'd1);
                if (expQ.size() == 0) begin
                    nVectors++;
                    nMiscompares++;
                    $display("[TB] FAIL line byte: got %0h expected none", monShift);
                end else begin
                    checkOutput("line byte", {24'd0, monShift}, {24'd0, expQ.pop_front()});
                end
                monActive = 0;
            end
        end
    end

    // Sends one message and checks acceptance/err, busy, done latency and the done pulse.
    task automatic applyStimulus(input int idx, input vec_t v, input bit disturb,
                                 input bit driveNow, input bit tailCheck);
        int         cycles;
        bit         sawDone, busyDrop, sawErr, badIdle;
        logic [7:0] exp[3];
        exp[0] = v.st;
        exp[1] = {1'b0, v.d1[6:0]};
        exp[2] = {1'b0, v.d2[6:0]};
        if (!v.isErr)
            for (int i = 0; i < v.len; i++) expQ.push_back(exp[i]);

        if (!driveNow) @(negedge clk);
        rst    = 1'b1;
        status = v.st;
        data1  = v.d1;
        data2  = v.d2;
        send   = 1'b1;
        @(posedge clk);
        #1;
        send = 1'b0;

        if (v.isErr) begin
            checkOutput($sformatf("vec%0d err pulse", idx), {31'd0, err}, 32'd1);
            checkOutput($sformatf("vec%0d rejected idle", idx), {30'd0, busy, midi_out}, 32'b01);
            sawErr  = 0;
            badIdle = 0;
            repeat (20) begin
                @(posedge clk);
                #1;
                if (err) sawErr = 1;
                if (busy || !midi_out) badIdle = 1;
            end
            checkOutput($sformatf("vec%0d err one cycle", idx), {31'd0, sawErr}, 32'd0);
            checkOutput($sformatf("vec%0d line idle", idx), {31'd0, badIdle}, 32'd0);
            return;
        end

        checkOutput($sformatf("vec%0d accept", idx), {30'd0, busy, midi_out}, 32'b10);
        cycles   = 0;
        sawDone  = 0;
        busyDrop = 0;
        sawErr   = 0;
        while (!sawDone && cycles < 4000) begin
            @(posedge clk);
            #1;
            cycles++;
            if (disturb && cycles == 50) begin
                status = 8'h45;
                data1  = 8'h11;
                data2  = 8'h22;
                send   = 1'b1;
            end
            if (disturb && cycles == 51) send = 1'b0;
            if (err) sawErr = 1;
            if (done) sawDone = 1;
            else if (!busy) busyDrop = 1;
        end
        checkOutput($sformatf("vec%0d done latency", idx), cycles, v.len * 10 * CPB);
        checkOutput($sformatf("vec%0d idle at done", idx), {30'd0, busy, midi_out}, 32'b01);
        checkOutput($sformatf("vec%0d busy held", idx), {31'd0, busyDrop}, 32'd0);
        checkOutput($sformatf("vec%0d no err", idx), {31'd0, sawErr}, 32'd0);
        if (tailCheck) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d done one cycle", idx), {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tbl[0]  = '{8'h90, 8'h3C, 8'h64, 3, 1'b0};
        tbl[1]  = '{8'hC5, 8'h07, 8'h55, 2, 1'b0};
        tbl[2]  = '{8'hF8, 8'h00, 8'h00, 1, 1'b0};
        tbl[3]  = '{8'h45, 8'h12, 8'h34, 0, 1'b1};
        tbl[4]  = '{8'hE0, 8'h11, 8'h22, 3, 1'b0};
        tbl[5]  = '{8'hD3, 8'h40, 8'h77, 2, 1'b0};
        tbl[6]  = '{8'hF2, 8'h05, 8'h06, 3, 1'b0};
        tbl[7]  = '{8'hF1, 8'h2A, 8'h33, 2, 1'b0};
        tbl[8]  = '{8'hF3, 8'h09, 8'h0A, 2, 1'b0};
        tbl[9]  = '{8'hF0, 8'h01, 8'h02, 1, 1'b0};
        tbl[10] = '{8'hBF, 8'h7F, 8'h00, 3, 1'b0};
        tbl[11] = '{8'h7F, 8'h01, 8'h01, 0, 1'b1};
        tbl[12] = '{8'h80, 8'hFF, 8'hFF, 3, 1'b0};
        tbl[13] = '{8'hFF, 8'h00, 8'h00, 1, 1'b0};
        tbl[14] = '{8'hDF, 8'h80, 8'h01, 2, 1'b0};
        tbl[15] = '{8'hEF, 8'hFF, 8'h7F, 3, 1'b0};
        tbl[16] = '{8'h00, 8'h00, 8'h00, 0, 1'b1};

        #1 rst = 1'b0;
        #2;
        checkOutput("reset state", {28'd0, midi_out, busy, done, err}, 32'b1000);
        status = 8'h90;
        send   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("send during reset", {28'd0, midi_out, busy, done, err}, 32'b1000);
        send = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("idle after reset", {28'd0, midi_out, busy, done, err}, 32'b1000);

        for (int i = 0; i < 17; i++) applyStimulus(i, tbl[i], 1'b0, 1'b0, 1'b1);

        // Re-pulsed send with changed inputs mid-message must be ignored.
        applyStimulus(100, tbl[0], 1'b1, 1'b0, 1'b1);

        // Back-to-back: next message requested in the done cycle.
        applyStimulus(200, tbl[2], 1'b0, 1'b0, 1'b0);
        applyStimulus(201, tbl[12], 1'b0, 1'b1, 1'b1);

        // Reset at clock 125 of a 3-byte message: only the status byte completes.
        @(negedge clk);
        expQ.push_back(8'h90);
        status = 8'h90;
        data1  = 8'h3C;
        data2  = 8'h64;
        send   = 1'b1;
        @(posedge clk);
        #1;
        send = 1'b0;
        repeat (125) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async reset", {28'd0, midi_out, busy, done, err}, 32'b1000);
        checkOutput("aborted queue", expQ.size(), 32'd0);
        expQ.delete();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("held in reset", {28'd0, midi_out, busy, done, err}, 32'b1000);
        applyStimulus(300, tbl[8], 1'b0, 1'b0, 1'b1);

        repeat (20) @(posedge clk);
        checkOutput("leftover bytes", expQ.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/midi_tx.md
MIDI_TX -- requirements
Module: midi_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 31250, meaning MIDI serial bit rate.
REQ-003 SHALL have parameter REG_WIDTH, default 8, meaning width of each message byte input.
REQ-004 SHALL have port clk  input  1  meaning the single system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  meaning asynchronous, active-low reset.
REQ-006 SHALL have port status  input  REG_WIDTH  meaning MIDI status byte from the wishbone MIDI register stage.
REQ-007 SHALL have port data1  input  REG_WIDTH  meaning first MIDI data byte.
REQ-008 SHALL have port data2  input  REG_WIDTH  meaning second MIDI data byte.
REQ-009 SHALL have port send  input  1  meaning request to transmit the message currently on status/data1/data2.
REQ-010 SHALL have port midi_out  output  1  meaning MIDI serial TX line, idle high, registered.
REQ-011 SHALL have port busy  output  1  meaning message in progress, registered.
REQ-012 SHALL have port done  output  1  meaning one-cycle pulse at message completion.
REQ-013 SHALL have port err  output  1  meaning one-cycle pulse when a request is rejected.

Function
REQ-014 SHALL derive CLKS_PER_BIT = CLK_FREQ/BAUD (integer division); each bit lasts exactly CLKS_PER_BIT clocks.
REQ-015 SHALL frame each byte as start bit 0, 8 data bits LSB first, stop bit 1: 10 bit times per byte.
REQ-016 SHALL use states IDLE, START, DATA, STOP; IDLE->START on accepted send, START->DATA, DATA->STOP after bit 7, STOP->START if bytes remain, else STOP->IDLE.
REQ-017 SHALL accept send only in IDLE; send while busy SHALL be ignored with no err and no effect on the transfer.
REQ-018 SHALL, at the accepting edge, latch status/data1/data2, drive midi_out to 0, and set busy to 1; later input changes SHALL not affect the message.
REQ-019 SHALL select message length from latched status: 0x80-0xBF and 0xE0-0xEF -> 3 bytes; 0xC0-0xDF, 0xF1, 0xF3 -> 2 bytes; 0xF2 -> 3 bytes; all other 0xF0-0xFF -> 1 byte.
REQ-020 SHALL reject status < 0x80 in IDLE: err pulses high one cycle on the following edge, busy stays 0, midi_out stays 1.
REQ-021 SHALL transmit bytes in order status, data1, data2, with no idle gap between the stop bit of one byte and the start bit of the next.
REQ-022 SHALL transmit data1 and data2 with bit 7 forced to 0.
REQ-023 SHALL, at the edge ending the last stop bit, return to IDLE, clear busy, and pulse done for exactly one cycle.
REQ-024 SHALL make total latency from accepting edge to done = N*10*CLKS_PER_BIT clocks, where N is the message length.
REQ-025 SHALL accept a send asserted in the same cycle done is high, since state is IDLE; the new start bit then begins on that edge.
REQ-026 SHALL use bit-timer and bit-index counters sized for CLKS_PER_BIT-1 and 0..9 without overflow; the bit timer SHALL reload at each bit boundary.

Reset
REQ-027 SHALL, on rst low at any time including mid-frame, immediately force IDLE, midi_out=1, busy=0, done=0, err=0, and clear counters and latched bytes.
REQ-028 SHALL resume operation on the first rising clk edge after rst deasserts; a send on that edge SHALL be accepted.

Verification (CLK_FREQ=312500, BAUD=31250 -> CLKS_PER_BIT=10)
REQ-029 SHALL verify status=0x90, data1=0x3C, data2=0x64, send pulse -> line carries 0x90,0x3C,0x64 LSB-first framed; busy high 300 clocks; done pulses at clock 300.
REQ-030 SHALL verify status=0xC5, data1=0x07 -> exactly 2 bytes sent; done at clock 200; data2 is never driven.
REQ-031 SHALL verify status=0xF8 -> 1 byte sent; done at clock 100. Separately, status=0x45 -> err pulse one cycle, busy=0, midi_out=1 throughout.
REQ-032 SHALL verify send re-pulsed and inputs changed at clock 50 of a 3-byte message -> original bytes sent unchanged; no err; done at clock 300 only.
REQ-033 SHALL verify rst low at clock 125 of a message -> midi_out=1 and busy=0 asynchronously; after release, a new send transmits cleanly from a start bit.
REQ-034 SHALL verify data1=0xFF -> transmitted as 0x7F; back-to-back send on the done cycle -> next start bit with no idle bit time.
